// File: rtl/genram_win_pkg.sv
// Shared definitions for the windowed RAM: fetch FSM states and request direction codes.
package genram_win_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/genram_core.sv
// Single-port synchronous RAM storage.
// One read or write per enabled cycle; the read is read-first and has no reset.
module genram_core #(
    parameter int AW = 5,
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/genram_win.sv
// Windowed RAM front end: accepts single-word writes and multi-word window reads.
// A fetch FSM assembles NW consecutive words into a shadow buffer before publishing them.
module genram_win
    import genram_win_pkg::*;
#(
    parameter int AW   = 5,
    parameter int DW   = 5,
    parameter int NW   = 2,
    parameter int WRAP = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req,
    input  logic             rw,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    data_in,
    output logic             busy,
    output logic             valid,
    output logic             oob,
    output logic [DW*NW-1:0] data_out
);

    localparam int SW = AW + 1;

    state_t            state;
    state_t            state_nx;
    logic [AW-1:0]     base;
    logic [SW-1:0]     k;
    logic [SW-1:0]     slot_addr;
    logic              slot_zero;
    logic              accept;
    logic              ram_en;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_q;
    logic              pend_valid;
    logic [SW-1:0]     pend_slot;
    logic              pend_zero;
    logic              oob_acc;
    logic [DW*NW-1:0]  shadow;
    logic [DW*NW-1:0]  shadow_nx;
    logic [DW-1:0]     word;

    // Slot addresses carry one extra bit so running off the top is detectable.
    assign slot_addr = {1'b0, base} + k;
    assign slot_zero = (WRAP == 0) && slot_addr[AW];
    assign accept    = (state == ST_IDLE) && req;
    assign ram_en    = accept || ((state == ST_FETCH) && !slot_zero);
    assign ram_we    = accept && (rw == RW_WRITE);
    assign ram_addr  = (state == ST_IDLE) ? addr : slot_addr[AW-1:0];
    assign busy      = (state != ST_IDLE);

    genram_core #(
        .AW(AW),
        .DW(DW)
    ) u_core (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(data_in),
        .q    (ram_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept && (rw == RW_READ)) state_nx = ST_FETCH;
            ST_FETCH: if (k == SW'(NW - 1)) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // The word issued last cycle lands in its slot now; the final slot merges straight into data_out.
    always_comb begin
        shadow_nx = shadow;
        word      = pend_zero ? '0 : ram_q;
        for (int i = 0; i < NW; i++) begin
            if (pend_valid && (pend_slot == SW'(i))) begin
                shadow_nx[i*DW +: DW] = word;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base       <= '0;
            k          <= '0;
            pend_valid <= 1'b0;
            pend_slot  <= '0;
            pend_zero  <= 1'b0;
            oob_acc    <= 1'b0;
            shadow     <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            oob        <= 1'b0;
        end else begin
            valid      <= 1'b0;
            pend_valid <= 1'b0;
            shadow     <= shadow_nx;
            case (state)
                ST_IDLE: begin
                    if (accept && (rw == RW_READ)) begin
                        base    <= addr;
                        k       <= '0;
                        oob_acc <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    k          <= k + SW'(1);
                    pend_valid <= 1'b1;
                    pend_slot  <= k;
                    pend_zero  <= slot_zero;
                    if (slot_zero) begin
                        oob_acc <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    valid    <= 1'b1;
                    data_out <= shadow_nx;
                    oob      <= oob_acc;
                end
                default: ;
            endcase
        end
    end

endmodule
